// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: turns a load/store into one req/ack data-memory
// transaction, places bytes on the correct lanes and extends load results.
module lsu_mem_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            WE,
    input  logic [1:0]      SIZE,
    input  logic            UNSIGNED,
    input  logic [XLEN-1:0] ADDR,
    input  logic [XLEN-1:0] WDATA,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR,
    output logic [XLEN-1:0] RDATA,
    output logic            MEM_REQ,
    output logic            MEM_WE,
    output logic [XLEN-1:0] MEM_ADDR,
    output logic [XLEN-1:0] MEM_WDATA,
    output logic [3:0]      MEM_BE,
    input  logic            MEM_ACK,
    input  logic [XLEN-1:0] MEM_RDATA
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            uns;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    state_t          state, nxt;
    lsu_req_t        req_q;
    logic            err_q;
    logic [7:0]      cnt_q;
    logic [XLEN-1:0] rdata_q;

    logic            misalign;
    logic            tmo_hit;
    logic            in_req;
    logic [3:0]      be;
    logic [XLEN-1:0] lane_rd;
    logic [XLEN-1:0] ld_ext;

    assign misalign = (SIZE == 2'b11) ||
                      (SIZE == 2'b01 && ADDR[0]) ||
                      (SIZE == 2'b10 && ADDR[1:0] != 2'b00);

    // Last REQ cycle before giving up: the counter has seen TIMEOUT-1 idle cycles.
    assign tmo_hit = (cnt_q == 8'(TIMEOUT - 1));
    assign in_req  = (state == S_REQ);

    always_comb begin
        be = 4'b1111;
        case (req_q.size)
            2'b00:   be = 4'b0001 << req_q.addr[1:0];
            2'b01:   be = 4'b0011 << req_q.addr[1:0];
            default: be = 4'b1111;
        endcase
    end

    assign lane_rd = MEM_RDATA >> {req_q.addr[1:0], 3'b000};

    always_comb begin
        ld_ext = lane_rd;
        case (req_q.size)
            2'b00: ld_ext = req_q.uns ? {{(XLEN-8){1'b0}}, lane_rd[7:0]}
                                      : {{(XLEN-8){lane_rd[7]}}, lane_rd[7:0]};
            2'b01: ld_ext = req_q.uns ? {{(XLEN-16){1'b0}}, lane_rd[15:0]}
                                      : {{(XLEN-16){lane_rd[15]}}, lane_rd[15:0]};
            default: ld_ext = lane_rd;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (START) nxt = misalign ? S_RESP : S_REQ;
            S_REQ:  if (MEM_ACK || tmo_hit) nxt = S_RESP;
            S_RESP: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (START) begin
                    req_q <= '{we: WE, size: SIZE, uns: UNSIGNED, addr: ADDR, wdata: WDATA};
                    err_q <= misalign;
                    cnt_q <= 8'd0;
                    if (misalign && !WE) rdata_q <= '0;
                end
                S_REQ: begin
                    // An ACK arriving in the timeout cycle still completes cleanly.
                    if (MEM_ACK) begin
                        err_q <= 1'b0;
                        if (!req_q.we) rdata_q <= ld_ext;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        if (!req_q.we) rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY      = ((state == S_IDLE) && START) || in_req;
    assign DONE      = (state == S_RESP);
    assign ERR       = DONE && err_q;
    assign RDATA     = rdata_q;
    assign MEM_REQ   = in_req;
    assign MEM_WE    = in_req && req_q.we;
    assign MEM_ADDR  = in_req ? {req_q.addr[XLEN-1:2], 2'b00} : '0;
    assign MEM_WDATA = in_req ? (req_q.wdata << {req_q.addr[1:0], 3'b000}) : '0;
    assign MEM_BE    = in_req ? be : 4'b0000;

endmodule
